// File: rtl/sipo_frame_ctrl_pkg.sv
// Shared types and helpers for the framed SIPO controller.
package sipo_ctrl_pkg;

    // Controller states: waiting for a frame, or assembling a word.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Counter width for a counter that must reach n-1; never narrower than one bit.
    function automatic int cntWidth(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

    // Bit counter width for a word of the given length.
    function automatic int bitCntWidth(input int width);
        return cntWidth(width);
    endfunction

    // Gap counter width for the given inter-bit timeout.
    function automatic int gapCntWidth(input int timeout);
        return cntWidth(timeout);
    endfunction

endpackage

// File: rtl/sipo_frame_ctrl_if.sv
// Serial front-end and parallel consumer signals of the framed SIPO controller.
interface sipo_frame_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             frame_start;
    logic             serial_valid;
    logic             serial_in;
    logic             out_ready;
    logic             clear_err;
    logic [WIDTH-1:0] parallel_out;
    logic             out_valid;
    logic             busy;
    logic             overrun_err;
    logic             abort_err;

    // Side that feeds the stream and consumes words.
    modport master (
        output frame_start,
        output serial_valid,
        output serial_in,
        output out_ready,
        output clear_err,
        input  parallel_out,
        input  out_valid,
        input  busy,
        input  overrun_err,
        input  abort_err
    );

    // The controller itself.
    modport slave (
        input  frame_start,
        input  serial_valid,
        input  serial_in,
        input  out_ready,
        input  clear_err,
        output parallel_out,
        output out_valid,
        output busy,
        output overrun_err,
        output abort_err
    );
endinterface

// File: rtl/sipo_frame_ctrl_shift_en.sv
// WIDTH-bit shift register: new bits enter at the MSB and move toward the LSB.
module sipo_shift_en #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] data_o
);
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next contents: shifted by one when enabled, otherwise held.
    always_comb begin
        data_d = data_q;
        if (shift_en_i) begin
            data_d = {bit_i, data_q[WIDTH-1:1]};
        end
    end

    // Register with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;
endmodule

// File: rtl/sipo_frame_ctrl.sv
// Framed serial-to-parallel controller: frame detection, bit counting,
// restart/timeout aborts, valid/ready holding register and sticky errors.
module sipo_frame_ctrl
    import sipo_ctrl_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int TIMEOUT    = 8,
    parameter int CONTINUOUS = 0
) (
    input logic             clk,
    input logic             reset,
    sipo_frame_ctrl_if.slave bus
);
    localparam int BCW = bitCntWidth(WIDTH);
    localparam int GCW = gapCntWidth(TIMEOUT);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);
    localparam logic [GCW-1:0] LAST_GAP = GCW'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [BCW-1:0]   bitCnt_q, bitCnt_d;
    logic [GCW-1:0]   gapCnt_q, gapCnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             outValid_q, outValid_d;
    logic             busy_q, busy_d;
    logic             overrun_q, overrun_d;
    logic             abort_q, abort_d;

    logic             shiftEn;
    logic             wordDone;
    logic             abortEv;
    logic             overrunEv;
    logic             loadHold;
    logic [WIDTH-1:0] srData;
    logic [WIDTH-1:0] word;

    // The LSB of the shift register is always shifted out by the completing
    // bit, so it never contributes to a delivered word.
    logic unusedLsb;
    assign unusedLsb = srData[0];

    sipo_shift_en #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk        (clk),
        .reset      (reset),
        .shift_en_i (shiftEn),
        .bit_i      (bus.serial_in),
        .data_o     (srData)
    );

    // The completing bit goes on top of the bits already collected.
    assign word = {bus.serial_in, srData[WIDTH-1:1]};

    // Sequencing decisions: restart, bit accept, completion and timeout.
    always_comb begin
        state_d  = state_q;
        bitCnt_d = bitCnt_q;
        gapCnt_d = gapCnt_q;
        shiftEn  = 1'b0;
        wordDone = 1'b0;
        abortEv  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.frame_start) begin
                    state_d  = SHIFT;
                    gapCnt_d = '0;
                    shiftEn  = bus.serial_valid;
                    bitCnt_d = bus.serial_valid ? BCW'(1) : '0;
                end
            end
            SHIFT: begin
                if (bus.frame_start) begin
                    abortEv  = (bitCnt_q != '0);
                    gapCnt_d = '0;
                    shiftEn  = bus.serial_valid;
                    bitCnt_d = bus.serial_valid ? BCW'(1) : '0;
                end else if (bus.serial_valid) begin
                    shiftEn  = 1'b1;
                    gapCnt_d = '0;
                    if (bitCnt_q == LAST_BIT) begin
                        wordDone = 1'b1;
                        bitCnt_d = '0;
                        state_d  = (CONTINUOUS != 0) ? SHIFT : IDLE;
                    end else begin
                        bitCnt_d = bitCnt_q + BCW'(1);
                    end
                end else if (gapCnt_q == LAST_GAP) begin
                    state_d  = IDLE;
                    bitCnt_d = '0;
                    gapCnt_d = '0;
                    abortEv  = (bitCnt_q != '0);
                end else begin
                    gapCnt_d = gapCnt_q + GCW'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                bitCnt_d = '0;
                gapCnt_d = '0;
            end
        endcase
    end

    // Holding register handshake, overrun detection and sticky flags.
    always_comb begin
        loadHold   = wordDone & (~outValid_q | bus.out_ready);
        overrunEv  = wordDone & ~loadHold;
        hold_d     = loadHold ? word : hold_q;
        outValid_d = outValid_q;
        if (loadHold) begin
            outValid_d = 1'b1;
        end else if (outValid_q && bus.out_ready) begin
            outValid_d = 1'b0;
        end
        busy_d    = (state_d == SHIFT);
        overrun_d = overrunEv | (overrun_q & ~bus.clear_err);
        abort_d   = abortEv | (abort_q & ~bus.clear_err);
    end

    // Single state register for the FSM, counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bitCnt_q   <= '0;
            gapCnt_q   <= '0;
            hold_q     <= '0;
            outValid_q <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitCnt_q   <= bitCnt_d;
            gapCnt_q   <= gapCnt_d;
            hold_q     <= hold_d;
            outValid_q <= outValid_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
            abort_q    <= abort_d;
        end
    end

    assign bus.parallel_out = hold_q;
    assign bus.out_valid    = outValid_q;
    assign bus.busy         = busy_q;
    assign bus.overrun_err  = overrun_q;
    assign bus.abort_err    = abort_q;
endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench: one instance in single-word mode, one in continuous mode,
// both fed the same stimulus.
module tb_sipo_frame_ctrl;
    logic clk;
    logic rst;
    logic fs, sv, si, ordy, clr;
    int   total;
    int   bad;

    sipo_frame_ctrl_if #(.WIDTH(4)) bus0 ();
    sipo_frame_ctrl_if #(.WIDTH(4)) bus1 ();

    assign bus0.frame_start  = fs;
    assign bus0.serial_valid = sv;
    assign bus0.serial_in    = si;
    assign bus0.out_ready    = ordy;
    assign bus0.clear_err    = clr;
    assign bus1.frame_start  = fs;
    assign bus1.serial_valid = sv;
    assign bus1.serial_in    = si;
    assign bus1.out_ready    = ordy;
    assign bus1.clear_err    = clr;

    sipo_frame_ctrl #(.WIDTH(4), .TIMEOUT(8), .CONTINUOUS(0)) dut0 (
        .clk   (clk),
        .reset (rst),
        .bus   (bus0)
    );

    sipo_frame_ctrl #(.WIDTH(4), .TIMEOUT(8), .CONTINUOUS(1)) dut1 (
        .clk   (clk),
        .reset (rst),
        .bus   (bus1)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs, then wait until just after the rising edge.
    task automatic applyStimulus(input logic f, input logic v, input logic b,
                                 input logic r, input logic c);
        fs   = f;
        sv   = v;
        si   = b;
        ordy = r;
        clr  = c;
        @(posedge clk);
        #1;
    endtask

    // One comparison point.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Synchronous reset for two cycles.
    task automatic doReset();
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        rst = 1'b0;
    endtask

    // Directed sequence.
    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        fs = 0; sv = 0; si = 0; ordy = 0; clr = 0;
        #2;
        doReset();
        checkOutput("rst_pout",    32'(bus0.parallel_out), 32'h0);
        checkOutput("rst_valid",   32'(bus0.out_valid),    32'h0);
        checkOutput("rst_busy",    32'(bus0.busy),         32'h0);
        checkOutput("rst_overrun", 32'(bus0.overrun_err),  32'h0);
        checkOutput("rst_abort",   32'(bus0.abort_err),    32'h0);

        // Basic word 1,0,1,1 -> 4'b1101
        applyStimulus(1, 1, 1, 1, 0);
        checkOutput("t1_busy_on", 32'(bus0.busy), 32'h1);
        applyStimulus(0, 1, 0, 1, 0);
        applyStimulus(0, 1, 1, 1, 0);
        checkOutput("t1_not_yet", 32'(bus0.out_valid), 32'h0);
        applyStimulus(0, 1, 1, 1, 0);
        checkOutput("t1_valid", 32'(bus0.out_valid),    32'h1);
        checkOutput("t1_word",  32'(bus0.parallel_out), 32'hD);
        checkOutput("t1_busy",  32'(bus0.busy),         32'h0);
        checkOutput("t1_cbusy", 32'(bus1.busy),         32'h1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("t1_consumed", 32'(bus0.out_valid), 32'h0);

        // Continuous mode overrun: F held, 0 dropped
        doReset();
        applyStimulus(1, 1, 1, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("t2_first", 32'(bus1.parallel_out), 32'hF);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("t2_no_ovr_yet", 32'(bus1.overrun_err), 32'h0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("t2_overrun", 32'(bus1.overrun_err),  32'h1);
        checkOutput("t2_held",    32'(bus1.parallel_out), 32'hF);
        checkOutput("t2_valid",   32'(bus1.out_valid),    32'h1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("t2_cleared", 32'(bus1.overrun_err),  32'h0);

        // Mid-word restart: 2 bits, then frame_start + 1,0,0,1 -> 4'b1001
        doReset();
        applyStimulus(1, 1, 0, 1, 0);
        applyStimulus(0, 1, 1, 1, 0);
        checkOutput("t3_no_abort", 32'(bus0.abort_err), 32'h0);
        applyStimulus(1, 1, 1, 1, 0);
        checkOutput("t3_abort", 32'(bus0.abort_err), 32'h1);
        applyStimulus(0, 1, 0, 1, 0);
        applyStimulus(0, 1, 0, 1, 0);
        applyStimulus(0, 1, 1, 1, 0);
        checkOutput("t3_valid", 32'(bus0.out_valid),    32'h1);
        checkOutput("t3_word",  32'(bus0.parallel_out), 32'h9);

        // Timeout after 2 bits
        doReset();
        applyStimulus(1, 1, 1, 1, 0);
        applyStimulus(0, 1, 0, 1, 0);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(0, 0, 0, 1, 0);
        end
        checkOutput("t4_busy_7",  32'(bus0.busy),      32'h1);
        checkOutput("t4_abort_7", 32'(bus0.abort_err), 32'h0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("t4_busy_8",  32'(bus0.busy),      32'h0);
        checkOutput("t4_abort_8", 32'(bus0.abort_err), 32'h1);
        checkOutput("t4_valid",   32'(bus0.out_valid), 32'h0);

        // Same-cycle consume and refill in continuous mode: 0001 then 1010
        doReset();
        applyStimulus(1, 1, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("t5_first", 32'(bus1.parallel_out), 32'h1);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 1, 1, 0);
        checkOutput("t5_valid",   32'(bus1.out_valid),    32'h1);
        checkOutput("t5_word",    32'(bus1.parallel_out), 32'hA);
        checkOutput("t5_overrun", 32'(bus1.overrun_err),  32'h0);

        // Continuous mode idles out at count 0 with no error
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 0, 1, 0);
        end
        checkOutput("t5_idle_busy",  32'(bus1.busy),      32'h0);
        checkOutput("t5_idle_abort", 32'(bus1.abort_err), 32'h0);

        // Reset mid-word, then 0,1,1,0 -> 4'b0110
        doReset();
        applyStimulus(1, 1, 1, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        rst = 1'b0;
        checkOutput("t6_rst_busy",  32'(bus0.busy),         32'h0);
        checkOutput("t6_rst_pout",  32'(bus0.parallel_out), 32'h0);
        checkOutput("t6_rst_valid", 32'(bus0.out_valid),    32'h0);
        applyStimulus(1, 1, 0, 1, 0);
        applyStimulus(0, 1, 1, 1, 0);
        applyStimulus(0, 1, 1, 1, 0);
        applyStimulus(0, 1, 0, 1, 0);
        checkOutput("t6_valid", 32'(bus0.out_valid),    32'h1);
        checkOutput("t6_word",  32'(bus0.parallel_out), 32'h6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sipo_frame_ctrl.md
Name: sipo_frame_ctrl

Overview:
Controller that sequences a WIDTH-bit serial-in parallel-out shift register for a framed serial stream. It detects frame start and counts bits. It aborts on mid-word restart or inter-bit timeout. Each completed word is handed to a downstream consumer through a valid/ready holding register. The block sits between a serial line front-end and the parallel datapath, and reports sticky error flags.

Parameters:
WIDTH, 4, bits per word; must be at least 2.
TIMEOUT, 8, consecutive SHIFT cycles without serial_valid before an abort; must be at least 2.
CONTINUOUS, 0. When 1, stay in SHIFT after a word completes (back-to-back words). When 0, return to IDLE.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
frame_start  input  1  start-of-frame strobe.
serial_valid  input  1  serial_in carries a valid bit this cycle.
serial_in  input  1  serial data bit.
out_ready  input  1  consumer accepts parallel_out this cycle.
clear_err  input  1  clears the sticky error flags.
parallel_out  output  WIDTH  assembled word from the holding register.
out_valid  output  1  parallel_out holds an unconsumed word.
busy  output  1  high when the FSM is in SHIFT.
overrun_err  output  1  sticky: a completed word was dropped because the holding register was full.
abort_err  output  1  sticky: a partial word was discarded by frame_start or by timeout.

Behaviour:
- Reset: every output and every internal register goes to 0, including the FSM, which goes to IDLE. Reset mid-word discards the partial word and any held word.
- Shift rule: each accepted bit enters the MSB and the register shifts toward the LSB. The first bit of a word therefore ends up at bit 0.
- FSM IDLE:
  - frame_start=1 and serial_valid=1: accept the bit, bit count becomes 1, go to SHIFT.
  - frame_start=1 and serial_valid=0: bit count becomes 0, go to SHIFT.
  - serial_valid without frame_start is ignored.
- FSM SHIFT, frame_start=1: the partial word is discarded and abort_err is set, but only if bit count > 0. Bit count restarts exactly as in IDLE, and the FSM stays in SHIFT.
- FSM SHIFT, serial_valid=1: shift the bit in, increment bit count, clear the gap counter.
- Word completion: happens when bit count == WIDTH-1 and serial_valid=1.
  - The complete word is the new bit concatenated above the upper WIDTH-1 bits of the shift register.
  - Bit count resets to 0.
  - Next state is SHIFT if CONTINUOUS=1, otherwise IDLE.
- Timeout:
  - The gap counter increments on every SHIFT cycle without serial_valid.
  - On the TIMEOUT-th consecutive such cycle, go to IDLE and clear bit count.
  - abort_err is set only if bit count > 0.
  - A SHIFT state with count 0 simply returns to IDLE with no error.
- Holding register load:
  - On word completion, load if out_valid=0, or if out_valid=1 and out_ready=1 (same-cycle consume-and-refill).
  - When loaded, parallel_out is valid from the next cycle, i.e. one cycle after the last bit.
  - Otherwise the word is dropped, overrun_err is set, and parallel_out and out_valid are unchanged.
- Handshake:
  - out_valid falls one cycle after out_valid and out_ready are both 1, unless a refill occurs in that same cycle.
  - parallel_out is stable while out_valid=1 and out_ready=0.
- Sticky flags: clear_err clears both flags. If clear_err and a new error event occur in the same cycle, the flag ends set.
- busy is registered and equals (state == SHIFT).
- Bit count width is clog2(WIDTH). Gap counter width is clog2(TIMEOUT). Neither counter wraps, because both are reset before reaching their limit.

Decomposition:
- Shared package sipo_ctrl_pkg holds:
  - the state enum (IDLE=0, SHIFT=1);
  - the width helper functions.
- One sub-module, sipo_shift_en: a WIDTH-bit MSB-in shift register with synchronous active-high reset and a shift-enable input.
- The controller holds the FSM, both counters, the holding register and the error flags.

Test Plan:
- WIDTH=4: frame_start together with bits 1,0,1,1 on consecutive cycles, out_ready=1 → out_valid=1 with parallel_out=4'b1101 one cycle after the fourth bit; busy=0 afterwards.
- CONTINUOUS=1, out_ready=0: send 8 bits, 1,1,1,1 then 0,0,0,0 → first word 4'hF is held, second word is dropped, overrun_err=1, parallel_out stays 4'hF. Then pulse clear_err → overrun_err=0.
- Send 2 bits, then frame_start with bit 1, then bits 0,0,1 → abort_err=1 and the delivered word is 4'b1001.
- Send 2 bits, then 8 idle cycles (TIMEOUT=8) → IDLE on the 8th idle cycle, abort_err=1, busy=0, out_valid stays 0.
- With out_valid=1 and out_ready=1 in the same cycle that a new word completes → out_valid stays 1, parallel_out updates to the new word, no overrun.
- Assert reset after 3 bits → all outputs 0. A following frame of 0,1,1,0 yields 4'b0110.
